// File: rtl/sram_controller.sv
// Purpose: bridges 32-bit MEM-stage loads/stores onto a 16-bit SRAM as two halfword accesses (low, then high).
// Latency: a request first seen at cycle 0 completes (ready=1) at cycle 2*WAIT_CYCLES+1; next accept at +2.
// Backpressure: ready is low from the arrival cycle until DONE; the pipeline stalls and holds its request.
module sram_controller #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [17:0] sram_addr,
  output logic [15:0] sram_dq_out,
  input  logic [15:0] sram_dq_in,
  output logic        sram_dq_oe,
  output logic        sram_we_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter value on the final cycle of each half; the strobe is released on that cycle.
  localparam logic [3:0] LAST = 4'(WAIT_CYCLES - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_op_wr;
  logic [16:0] r_word;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [17:0] r_sram_addr;
  logic [15:0] r_dq_out;
  logic        r_dq_oe;
  logic        r_we_n;

  logic [16:0] w_word;
  logic        w_last;
  logic        w_next_last;

  // Word index relative to the SRAM window; wraps modulo 2^17 for addresses below the base.
  assign w_word      = 17'((address - BASE_ADDR) >> 2);
  assign w_last      = (r_cnt == LAST);
  assign w_next_last = ((r_cnt + 4'd1) == LAST);

  // Ready is combinational so an idle controller never stalls the pipeline.
  assign ready = (r_state == DONE) || ((r_state == IDLE) && !wr_en && !rd_en);

  assign rdata       = r_rdata;
  assign sram_addr   = r_sram_addr;
  assign sram_dq_out = r_dq_out;
  assign sram_dq_oe  = r_dq_oe;
  assign sram_we_n   = r_we_n;

  // Access sequencer: state, wait counter, read capture and registered SRAM pins, all decided per transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_op_wr     <= 1'b0;
      r_word      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_sram_addr <= '0;
      r_dq_out    <= '0;
      r_dq_oe     <= 1'b0;
      r_we_n      <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (wr_en || rd_en) begin
            // Write wins when both enables are high; request fields are frozen here.
            r_state     <= LOW;
            r_cnt       <= '0;
            r_op_wr     <= wr_en;
            r_word      <= w_word;
            r_wdata     <= wdata;
            r_sram_addr <= {w_word, 1'b0};
            r_dq_out    <= wdata[15:0];
            r_dq_oe     <= wr_en;
            r_we_n      <= ~wr_en;
          end
        end
        LOW: begin
          if (w_last) begin
            r_state     <= HIGH;
            r_cnt       <= '0;
            r_sram_addr <= {r_word, 1'b1};
            r_dq_out    <= r_wdata[31:16];
            r_we_n      <= ~r_op_wr;
            if (!r_op_wr) begin
              r_rdata[15:0] <= sram_dq_in;
            end
          end else begin
            r_cnt  <= r_cnt + 4'd1;
            // Strobe stays low until the last cycle of the half, which acts as data hold.
            r_we_n <= ~r_op_wr || w_next_last;
          end
        end
        HIGH: begin
          if (w_last) begin
            r_state     <= DONE;
            r_cnt       <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            if (!r_op_wr) begin
              r_rdata[31:16] <= sram_dq_in;
            end
          end else begin
            r_cnt  <= r_cnt + 4'd1;
            r_we_n <= ~r_op_wr || w_next_last;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench: randomized loads/stores against a word-level memory model, plus a WAIT_CYCLES=5 latency probe.
// Stimulus issues requests and pushes expectations; a negedge monitor checks bus activity and completions.
// A watchdog bounds the whole run.
module tb_sram_controller;

  localparam int          W    = 2;
  localparam int          W5   = 5;
  localparam logic [31:0] BASE = 32'd1024;

  typedef struct {
    logic        wr;
    logic [16:0] word;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, rd_en;
  logic [31:0] address, wdata, rdata;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n;

  logic        w5_wr, w5_rd;
  logic [31:0] w5_addr, w5_wdata, w5_rdata;
  logic        w5_ready;
  logic [17:0] w5_sram_addr;
  logic [15:0] w5_dq_out, w5_dq;
  logic        w5_oe, w5_we_n;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   we_low = 0;
  int   oe_cnt = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  logic [31:0] ref_mem [logic [16:0]];
  logic [31:0] last_rdata;

  logic [15:0] mem [0:262143];
  bit          written [0:262143];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_controller #(.WAIT_CYCLES(W), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address), .wdata(wdata),
    .rdata(rdata), .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
    .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n)
  );

  sram_controller #(.WAIT_CYCLES(W5), .BASE_ADDR(BASE)) dut5 (
    .clk(clk), .rst(rst), .wr_en(w5_wr), .rd_en(w5_rd), .address(w5_addr), .wdata(w5_wdata),
    .rdata(w5_rdata), .ready(w5_ready), .sram_addr(w5_sram_addr), .sram_dq_out(w5_dq_out),
    .sram_dq_in(w5_dq), .sram_dq_oe(w5_oe), .sram_we_n(w5_we_n)
  );

  // Power-on SRAM content: halfwords 0/1 hold 0x1234/0xABCD, everything else a fixed hash of the address.
  function automatic logic [15:0] init_pat(input logic [17:0] a);
    logic [31:0] h;
    if (a == 18'd0) return 16'h1234;
    if (a == 18'd1) return 16'hABCD;
    h = ({14'd0, a} * 32'h9E3779B1) ^ 32'h5BD1E995;
    return h[23:8];
  endfunction

  function automatic logic [15:0] sram_rd(input logic [17:0] a);
    return written[a] ? mem[a] : init_pat(a);
  endfunction

  assign sram_dq_in = sram_rd(sram_addr);

  // Asynchronous SRAM model: a halfword is stored on any edge where the bus is driven with the strobe low.
  always @(posedge clk) begin
    if (sram_dq_oe && !sram_we_n) begin
      mem[sram_addr]     <= sram_dq_out;
      written[sram_addr] <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
    end
  endtask

  // Monitor: checks bus behaviour of the in-flight request each cycle and scores it when ready rises.
  always @(negedge clk) begin
    if (!rst) begin
      if (sb_q.size() == 0) begin
        chk("idle_bus", {30'd0, sram_dq_oe, sram_we_n}, 32'd1);
      end else begin
        mon_e = sb_q[0];
        if (!mon_e.wr) begin
          chk("rd_bus", {30'd0, sram_dq_oe, sram_we_n}, 32'd1);
        end else if (sram_dq_oe) begin
          chk("wr_word", 32'(sram_addr[17:1]), 32'(mon_e.word));
          chk("wr_half", 32'(sram_addr[0]), (oe_cnt >= W) ? 32'd1 : 32'd0);
          chk("wr_dq", 32'(sram_dq_out), sram_addr[0] ? 32'(mon_e.wdata[31:16]) : 32'(mon_e.wdata[15:0]));
          oe_cnt++;
        end else begin
          chk("wr_hold", 32'(sram_we_n), 32'd1);
        end
        if (!sram_we_n) we_low++;
        if ((wr_en || rd_en) && ready) begin
          chk("latency", 32'(cyc - mon_e.start), 32'(2 * W + 1));
          chk("rdata", rdata, mon_e.rdata);
          chk("we_low_cycles", 32'(we_low), mon_e.wr ? 32'(2 * (W - 1)) : 32'd0);
          chk("oe_cycles", 32'(oe_cnt), mon_e.wr ? 32'(2 * W) : 32'd0);
          void'(sb_q.pop_front());
          we_low = 0;
          oe_cnt = 0;
        end
      end
    end
  end

  // Issue one request at the current cycle and hold it until the controller reports completion.
  task automatic do_txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input bit scramble);
    exp_t        e;
    logic [16:0] word;
    bit          got;
    word    = 17'((a - BASE) >> 2);
    e.wr    = w;
    e.word  = word;
    e.wdata = d;
    e.start = cyc;
    if (!ref_mem.exists(word)) ref_mem[word] = {init_pat({word, 1'b1}), init_pat({word, 1'b0})};
    if (w) begin
      ref_mem[word] = d;
      e.rdata       = last_rdata;
    end else begin
      e.rdata    = ref_mem[word];
      last_rdata = e.rdata;
    end
    sb_q.push_back(e);
    wr_en = w; rd_en = r; address = a; wdata = d;
    got = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      if (scramble) begin
        address = $urandom;
        wdata   = $urandom;
      end
    end
    chk("txn_complete", 32'(got), 32'd1);
    if (!got && sb_q.size() > 0) void'(sb_q.pop_front());
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int          kind, idx, gap, start5;
    logic [31:0] a;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; wdata = '0;
    w5_wr = 1'b0; w5_rd = 1'b0; w5_addr = '0; w5_wdata = '0; w5_dq = '0;
    last_rdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_we_n", 32'(sram_we_n), 32'd1);
    chk("reset_oe", 32'(sram_dq_oe), 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    chk("reset_addr", 32'(sram_addr), 32'd0);
    @(posedge clk); #1;

    // Directed: preset word 0 read, store to 1028, store/load back-to-back, both enables.
    do_txn(1'b0, 1'b1, 32'd1024, 32'd0, 1'b0);
    chk("read_word0", rdata, 32'hABCD1234);
    do_txn(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 1'b0);
    do_txn(1'b1, 1'b0, 32'd1032, 32'hCAFEF00D, 1'b0);
    do_txn(1'b0, 1'b1, 32'd1032, 32'd0, 1'b0);
    chk("read_back_1032", rdata, 32'hCAFEF00D);
    do_txn(1'b1, 1'b1, 32'd1040, 32'h0F1E2D3C, 1'b0);
    chk("both_rdata_kept", rdata, 32'hCAFEF00D);
    do_txn(1'b1, 1'b0, BASE - 32'd4, 32'h55AA33CC, 1'b0);
    do_txn(1'b0, 1'b1, BASE - 32'd2, 32'd0, 1'b0);

    // Reset in the middle of a store (request at cycle 0, reset edge ends cycle 3).
    sb_q.push_back('{wr: 1'b1, word: 17'd3, wdata: 32'h0BADF00D, rdata: 32'd0, start: cyc});
    wr_en = 1'b1; address = BASE + 32'd12; wdata = 32'h0BADF00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1; wr_en = 1'b0;
    sb_q.delete();
    we_low = 0; oe_cnt = 0; last_rdata = '0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 32'(ready), 32'd1);
    chk("abort_we_n", 32'(sram_we_n), 32'd1);
    chk("abort_oe", 32'(sram_dq_oe), 32'd0);
    chk("abort_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    do_txn(1'b1, 1'b0, BASE + 32'd12, 32'h13579BDF, 1'b0);

    // Randomized traffic over 16 words, with misaligned byte offsets and idle gaps.
    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 9);
      idx  = $urandom_range(0, 15);
      a    = BASE + 32'(idx * 4) + 32'($urandom_range(0, 3));
      if (kind <= 3)      do_txn(1'b0, 1'b1, a, $urandom, 1'b1);
      else if (kind <= 8) do_txn(1'b1, 1'b0, a, $urandom, 1'b1);
      else                do_txn(1'b1, 1'b1, a, $urandom, 1'b1);
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end

    // SRAM contents must match the word-level model.
    foreach (ref_mem[k]) begin
      chk("mem_lo", 32'(sram_rd({k, 1'b0})), 32'(ref_mem[k][15:0]));
      chk("mem_hi", 32'(sram_rd({k, 1'b1})), 32'(ref_mem[k][31:16]));
    end

    // Five wait cycles per half: completion lands on cycle 11.
    for (int k = 0; k < 3; k++) begin
      w5_dq   = 16'($urandom);
      w5_rd   = 1'b1;
      w5_addr = BASE + 32'(4 * k);
      start5  = cyc;
      for (int j = 0; j < 40; j++) begin
        @(negedge clk);
        if (w5_ready) break;
      end
      chk("w5_latency", 32'(cyc - start5), 32'(2 * W5 + 1));
      chk("w5_rdata", w5_rdata, {w5_dq, w5_dq});
      @(posedge clk); #1;
      w5_rd = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
